// File: rtl/ram4k_pkg.sv
// ram4k_pkg: shared widths and encodings for the RAM4k loader.
package ram4k_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;
    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_DUMP = 1'b1;
endpackage

// File: rtl/ram4k_loader.sv
// ram4k_loader: bulk-fills a RAM4k range from a valid/ready stream or dumps a range back out.
// Owns the RAM in/load/sel pins; the RAM read port is combinational.
module ram4k_loader #(
    parameter int ADDR_W = ram4k_pkg::ADDR_W,
    parameter int DATA_W = ram4k_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_sel,
    input  logic [DATA_W-1:0] ram_out
);
    import ram4k_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_len;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_valid;
    logic              w_fire_s;
    logic              w_issue;
    logic              w_consume;
    logic              w_last;

    assign w_fire_s  = (r_state == ST_FILL) && s_valid;
    assign w_issue   = (r_state == ST_DUMP) && (!r_m_valid || m_ready) && (r_issued < r_len);
    assign w_consume = (r_state == ST_DUMP) && r_m_valid && m_ready;
    assign w_last    = r_remaining == (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = !start ? ST_IDLE :
                              (length == '0) ? ST_DONE :
                              (mode == MODE_DUMP) ? ST_DUMP : ST_FILL;
            ST_FILL: w_next = (w_fire_s && w_last) ? ST_DONE : ST_FILL;
            ST_DUMP: w_next = (w_consume && w_last) ? ST_DONE : ST_DUMP;
            default: w_next = ST_IDLE;
        endcase
    end

    // Gating with rst_n drops the write strobe the instant reset asserts.
    assign ram_load = w_fire_s && rst_n;
    assign ram_in   = s_data;
    assign ram_sel  = r_addr;
    assign s_ready  = r_state == ST_FILL;
    assign busy     = r_state != ST_IDLE;
    assign done     = r_state == ST_DONE;
    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_issued    <= '0;
            r_len       <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_addr      <= base_addr;
                r_remaining <= length;
                r_len       <= length;
                r_issued    <= '0;
            end
            if (w_fire_s || w_issue)
                r_addr <= r_addr + 1'b1;
            if (w_fire_s || w_consume)
                r_remaining <= r_remaining - 1'b1;
            if (w_issue) begin
                r_issued  <= r_issued + 1'b1;
                r_m_data  <= ram_out;
                r_m_valid <= 1'b1;
            end else if (w_consume) begin
                r_m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ram4k_loader.sv
// tb_ram4k_loader: directed scenarios against ram4k_loader driving a behavioural RAM4k.
module tb_ram4k_loader;
    import ram4k_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] length = '0;
    logic        busy, done;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [11:0] ram_sel;
    logic [15:0] ram_out;
    logic [15:0] mem [4096] = '{default: 16'h0};
    int          checks = 0;
    int          errors = 0;
    logic [15:0] fd [4] = '{16'hF00D, 16'hBEEF, 16'h1234, 16'hCAFE};

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_load) mem[ram_sel] <= ram_in;
    assign ram_out = mem[ram_sel];

    ram4k_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_in(ram_in), .ram_load(ram_load), .ram_sel(ram_sel), .ram_out(ram_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, s_ready, m_valid, ram_load, m_data, ram_sel} !== {5'b0, 16'h0, 12'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b s_ready=%b m_valid=%b load=%b m_data=%h sel=%h, want all zero",
                     busy, done, s_ready, m_valid, ram_load, m_data, ram_sel);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_dump();
        start = 1'b1; mode = MODE_FILL; base_addr = 12'h958; length = 13'd4;
        s_valid = 1'b1; s_data = fd[0];
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_data = fd[i];
            #1;
            checks++;
            if ({ram_load, s_ready, ram_sel, ram_in} !== {2'b11, 12'h958 + 12'(i), fd[i]}) begin
                errors++;
                $display("FAIL fill_write[%0d]: got load=%b rdy=%b sel=%h in=%h, want load=1 rdy=1 sel=%h in=%h",
                         i, ram_load, s_ready, ram_sel, ram_in, 12'h958 + 12'(i), fd[i]);
            end
            tick();
        end
        s_valid = 1'b0;
        checks++;
        if ({done, busy, ram_load} !== 3'b110) begin
            errors++;
            $display("FAIL fill_done: got done=%b busy=%b load=%b, want 1 1 0", done, busy, ram_load);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL fill_idle: got done=%b busy=%b, want 0 0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[12'h958 + 12'(i)] !== fd[i]) begin
                errors++;
                $display("FAIL fill_mem[%0d]: got %h want %h", i, mem[12'h958 + 12'(i)], fd[i]);
            end
        end
        // back-to-back: start in the cycle right after done
        start = 1'b1; mode = MODE_DUMP; base_addr = 12'h958; length = 13'd4; m_ready = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_first_cycle: got m_valid=%b want 0", m_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({m_valid, m_data} !== {1'b1, fd[i]}) begin
                errors++;
                $display("FAIL dump_word[%0d]: got valid=%b data=%h, want 1 %h", i, m_valid, m_data, fd[i]);
            end
            tick();
        end
        checks++;
        if ({done, m_valid} !== 2'b10) begin
            errors++;
            $display("FAIL dump_done: got done=%b m_valid=%b, want 1 0", done, m_valid);
        end
        tick();
    endtask

    task automatic test_wrap();
        start = 1'b1; mode = MODE_FILL; base_addr = 12'hFFE; length = 13'd4;
        s_valid = 1'b1; s_data = 16'hA0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'hA0 + 16'(i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if ({mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]} !== {16'hA0, 16'hA1, 16'hA2, 16'hA3}) begin
            errors++;
            $display("FAIL wrap_mem: got %h %h %h %h want a0 a1 a2 a3",
                     mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]);
        end
    endtask

    task automatic test_backpressure();
        logic        rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] exp [6] = '{16'hF00D, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h1234, 16'h1234};
        start = 1'b1; mode = MODE_DUMP; base_addr = 12'h958; length = 13'd3; m_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            m_ready = rdy[i];
            checks++;
            if ({m_valid, m_data, done} !== {1'b1, exp[i], 1'b0}) begin
                errors++;
                $display("FAIL bp_cycle[%0d]: got valid=%b data=%h done=%b, want 1 %h 0",
                         i, m_valid, m_data, done, exp[i]);
            end
            tick();
        end
        m_ready = 1'b0;
        checks++;
        if ({done, m_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_done: got done=%b m_valid=%b, want 1 0", done, m_valid);
        end
        tick();
    endtask

    task automatic test_stall();
        logic        vld [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [11:0] sel [5] = '{12'h100, 12'h101, 12'h101, 12'h102, 12'h102};
        start = 1'b1; mode = MODE_FILL; base_addr = 12'h100; length = 13'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = vld[i];
            s_data = 16'h11 * 16'(i + 1);
            #1;
            checks++;
            if ({ram_load, ram_sel} !== {vld[i], sel[i]}) begin
                errors++;
                $display("FAIL stall_cycle[%0d]: got load=%b sel=%h, want %b %h",
                         i, ram_load, ram_sel, vld[i], sel[i]);
            end
            tick();
        end
        s_valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: got done=%b want 1", done);
        end
        tick();
        checks++;
        if ({mem[12'h0FF], mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]} !==
            {16'h0, 16'h11, 16'h33, 16'h55, 16'h0}) begin
            errors++;
            $display("FAIL stall_mem: got %h %h %h %h %h want 0 11 33 55 0",
                     mem[12'h0FF], mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        start = 1'b1; mode = MODE_FILL; base_addr = 12'h700; length = 13'd0; s_valid = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, ram_load} !== 2'b10) begin
            errors++;
            $display("FAIL zero_len: got done=%b load=%b, want 1 0", done, ram_load);
        end
        s_valid = 1'b0;
        tick();
        start = 1'b1; mode = MODE_FILL; base_addr = 12'h200; length = 13'd3;
        s_valid = 1'b1; s_data = 16'h301;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_data = 16'h301 + 16'(i);
            if (i == 1) begin
                start = 1'b1; mode = MODE_DUMP; base_addr = 12'h300; length = 13'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            checks++;
            if ({ram_load, ram_sel} !== {1'b1, 12'h200 + 12'(i)}) begin
                errors++;
                $display("FAIL ignored_start[%0d]: got load=%b sel=%h, want 1 %h",
                         i, ram_load, ram_sel, 12'h200 + 12'(i));
            end
            tick();
        end
        start = 1'b0;
        s_valid = 1'b0;
        checks++;
        if ({done, m_valid} !== 2'b10) begin
            errors++;
            $display("FAIL ignored_done: got done=%b m_valid=%b, want 1 0", done, m_valid);
        end
        tick();
        checks++;
        if ({mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h300], mem[12'h700]} !==
            {16'h301, 16'h302, 16'h303, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL ignored_mem: got %h %h %h %h %h want 301 302 303 0 0",
                     mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h300], mem[12'h700]);
        end
    endtask

    task automatic test_reset_mid_fill();
        start = 1'b1; mode = MODE_FILL; base_addr = 12'h400; length = 13'd8;
        s_valid = 1'b1; s_data = 16'h500;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_data = 16'h500 + 16'(i);
            tick();
        end
        s_data = 16'h502;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_load, busy, done, s_ready, m_valid, m_data, ram_sel} !== {5'b0, 16'h0, 12'h0}) begin
            errors++;
            $display("FAIL reset_mid_outputs: got load=%b busy=%b done=%b rdy=%b mv=%b md=%h sel=%h, want all zero",
                     ram_load, busy, done, s_ready, m_valid, m_data, ram_sel);
        end
        tick();
        checks++;
        if ({mem[12'h400], mem[12'h401], mem[12'h402], mem[12'h000]} !== {16'h500, 16'h501, 16'h0, 16'hA2}) begin
            errors++;
            $display("FAIL reset_mid_mem: got %h %h %h %h want 500 501 0 a2",
                     mem[12'h400], mem[12'h401], mem[12'h402], mem[12'h000]);
        end
        s_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        start = 1'b1; mode = MODE_FILL; base_addr = 12'h410; length = 13'd2;
        s_valid = 1'b1; s_data = 16'h6A;
        tick();
        start = 1'b0;
        tick();
        s_data = 16'h6B;
        tick();
        s_valid = 1'b0;
        checks++;
        if ({done, mem[12'h410], mem[12'h411]} !== {1'b1, 16'h6A, 16'h6B}) begin
            errors++;
            $display("FAIL refill_after_reset: got done=%b %h %h want 1 6a 6b", done, mem[12'h410], mem[12'h411]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_dump();
        test_wrap();
        test_backpressure();
        test_stall();
        test_zero_and_ignored_start();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram4k_loader.md
# ram4k_loader

Sequencer that sits directly upstream of the 4K×16 RAM and owns its `in`/`load`/`sel` pins. It bulk-fills a contiguous address range from a valid/ready input stream, or dumps a range back out onto a valid/ready output stream. It gives bootstrap logic and testbenches one block-level path to load and inspect RAM contents without driving individual words.

## Interface
Parameters:
- `ADDR_W`, 12, RAM address width; the address space is 2^ADDR_W words.
- `DATA_W`, 16, word width.

Ports:
- `clk`  in  1  Rising-edge clock; shared with the RAM.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Starts a transfer; sampled only in IDLE.
- `mode`  in  1  Transfer type: 0 = fill, 1 = dump. Captured with `start`.
- `base_addr`  in  ADDR_W  First RAM address. Captured with `start`.
- `length`  in  ADDR_W+1  Word count, 0..4096. Captured with `start`.
- `busy`  out  1  High in FILL, DUMP and DONE.
- `done`  out  1  One-cycle pulse at the end of every accepted transfer.
- `s_data`  in  DATA_W  Fill stream data.
- `s_valid`  in  1  Fill stream valid.
- `s_ready`  out  1  Fill stream ready.
- `m_data`  out  DATA_W  Dump stream data (registered).
- `m_valid`  out  1  Dump stream valid (registered).
- `m_ready`  in  1  Dump stream ready.
- `ram_in`  out  DATA_W  Connects to RAM `in`.
- `ram_load`  out  1  Connects to RAM `load`.
- `ram_sel`  out  ADDR_W  Connects to RAM `sel`.
- `ram_out`  in  DATA_W  Connects to RAM `out`; a combinational read of `ram_sel`.

## Operation
- **States:** IDLE, FILL, DUMP, DONE. Reset puts the block in IDLE.
- **IDLE:**
  - If `start`=1, latch `addr <= base_addr` and `remaining <= length`.
  - Next state: DONE if `length`=0, otherwise FILL (`mode`=0) or DUMP (`mode`=1).
- **FILL:**
  - `s_ready`=1.
  - `ram_in`=`s_data`, `ram_sel`=`addr`, `ram_load`=`s_valid`. These are combinational, so the word is written on the same edge as the handshake.
  - Per accepted word: `addr <= addr+1` (mod 2^ADDR_W) and `remaining <= remaining-1`.
  - The handshake with `remaining`=1 moves to DONE.
- **DUMP:**
  - `ram_load`=0 and `ram_sel`=`addr`.
  - Issue condition: `(!m_valid || m_ready) && issued_count < length`.
  - When the issue condition holds: `m_data <= ram_out`, `m_valid <= 1`, and `addr` increments.
  - When `m_valid && m_ready` and no issue occurs: `m_valid <= 0`.
  - After the last word is consumed, move to DONE.
  - `remaining` counts consumed words; issues are tracked by a separate `issued` counter.
- **DONE:**
  - `done`=1 for exactly one cycle, then IDLE.
- **Outputs outside the owning state:** `s_ready`=0, `ram_load`=0, `ram_sel`=`addr`, `ram_in`=`s_data`.
- **Address wrap:** `addr` wraps 4095→0 without error. With `length`=4096, every word is written exactly once.
- **`start` while busy:** ignored; the captured `mode`, `base_addr` and `length` are unaffected.
- **Reset, including mid-transfer:**
  - `ram_load`=0 immediately (asynchronously), so no partial write occurs after reset assertion.
  - State=IDLE; `addr`, `remaining` and `issued` = 0.
  - `m_valid`=0, `m_data`=0, `done`=0, `busy`=0, `s_ready`=0.

## Timing
- **Fill:** one word per cycle at full throughput. The write lands on the handshake edge, and RAM `out` at that address reflects it in the following cycle.
- **Dump:**
  - The first `m_valid` appears one cycle after entering DUMP.
  - Sustained rate is one word per cycle while `m_ready`=1.
  - Backpressure holds `m_data`/`m_valid` stable, with no skipped or repeated address.
- **Transfer overhead:**
  - From the `start` cycle to the first possible fill handshake: 1 cycle.
  - `done` is asserted in the cycle after the last fill handshake or the last dump consume.
- **Back-to-back transfers:** `start` is accepted in the cycle after `done`.

## Structure
- Shared package `ram4k_pkg`:
  - `ADDR_W`, `DATA_W`.
  - State encoding constants `ST_IDLE`=0, `ST_FILL`=1, `ST_DUMP`=2, `ST_DONE`=3.
  - Mode constants `MODE_FILL`=0, `MODE_DUMP`=1.
- Single module with no sub-modules.
- Top-level integration instantiates `ram4k_loader` next to the existing RAM4k, wired on `in`/`load`/`sel`/`out`.

## Test plan
- **Fill then dump:** `start`, `mode`=0, `base_addr`=0x958, `length`=4, `s_data` = 0xF00D, 0xBEEF, 0x1234, 0xCAFE, `s_valid` held high.
  - Required: writes at 0x958–0x95B on 4 consecutive edges, `done` pulse.
  - Then dump the same range with `m_ready`=1: `m_data` sequence identical, 4 consecutive valid cycles.
- **Wrap-around:** fill `base_addr`=0xFFE, `length`=4 with 0xA0–0xA3.
  - Required: RAM[0xFFE]=0xA0, RAM[0xFFF]=0xA1, RAM[0x000]=0xA2, RAM[0x001]=0xA3.
- **Backpressure:** dump a 3-word range with `m_ready` toggling 1,0,0,1,0,1.
  - Required: each word is held stable while stalled, order preserved, `done` one cycle after the third consume.
- **Stalled input:** fill with `s_valid` gaps (1,0,1,0,1).
  - Required: `ram_load` is high only on valid cycles, `addr` advances only on handshakes, and unselected addresses are untouched.
- **Zero length and ignored start:** `length`=0.
  - Required: `done` one cycle after `start`, no `ram_load`.
  - `start` pulsed mid-transfer: ignored, and the original transfer completes unchanged.
- **Reset mid-fill:** assert `rst_n`=0 after 2 of 8 words.
  - Required: `ram_load` falls immediately, outputs take their reset values, only the first 2 words are written, and a fresh fill succeeds afterwards.
